// File: rtl/aes_ks_pkg.sv
// Shared types and helpers for the AES key-expansion engine and round-key store.
package aes_ks_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_RSV = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } ks_state_e;

  // Key length in 32-bit words; 0 marks the reserved encoding.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES S-box (GF(2^8) inverse plus affine map) and the 32-bit SubWord built from four of them.
module aes_sbox
  import aes_ks_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] sq;
  logic [7:0] inv;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as a^254 by square-and-multiply; 0 maps to 0 naturally.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_subword (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (word_in[8*b +: 8]),
      .s (word_out[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_schedule_store.sv
// AES-128/192/256 key expansion, one word per cycle, into a word store with a
// combinational round-key read port in encryption or decryption order.
module aes_key_schedule_store
  import aes_ks_pkg::*;
#(
  parameter int unsigned MAX_NK = 8,
  parameter int unsigned RW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [32*MAX_NK-1:0] key_in,
  output logic                busy,
  output logic                ready,
  output logic                err,
  output logic [3:0]          nr,
  input  logic [RW-1:0]       rd_idx,
  input  logic                rd_dec,
  output logic [127:0]        rd_key
);

  localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned KW    = 32 * MAX_NK;

  ks_state_e        state_q, state_d;
  logic [IW-1:0]    i_q, i_d;
  logic [2:0]       mod_q, mod_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [3:0]       nk_q, nk_d;
  logic [3:0]       nr_q, nr_d;
  logic [KW-1:0]    key_q, key_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      w_q [DEPTH];

  logic [3:0]       nk_req_c;
  logic             legal_c;
  logic [31:0]      prev_w_c;
  logic [31:0]      back_w_c;
  logic [31:0]      sub_in_c;
  logic [31:0]      sub_out_c;
  logic [31:0]      temp_c;
  logic             last_c;
  logic             load_c;
  logic             wr_en_c;
  logic [IW-1:0]    wr_idx_c;
  logic [31:0]      wr_data_c;
  logic [RW-1:0]    r_c;
  logic [IW-1:0]    base_c;

  aes_subword u_subword (
    .word_in  (sub_in_c),
    .word_out (sub_out_c)
  );

  // Word recurrence: mod_q tracks i mod Nk so no divider is needed.
  always_comb begin
    nk_req_c = nk_of(key_len);
    legal_c  = (nk_req_c != 4'd0) && (32'(nk_req_c) <= MAX_NK);
    prev_w_c = w_q[i_q - IW'(1)];
    back_w_c = w_q[i_q - IW'(nk_q)];
    sub_in_c = (mod_q == 3'd0) ? {prev_w_c[23:0], prev_w_c[31:24]} : prev_w_c;
    if (mod_q == 3'd0) begin
      temp_c = sub_out_c ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
      temp_c = sub_out_c;
    end else begin
      temp_c = prev_w_c;
    end
    last_c = (i_q == IW'((32'(nr_q) + 32'd1) * 32'd4 - 32'd1));
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    mod_d     = mod_q;
    rcon_d    = rcon_q;
    nk_d      = nk_q;
    nr_d      = nr_q;
    key_d     = key_q;
    err_d     = 1'b0;
    load_c    = 1'b0;
    wr_en_c   = 1'b0;
    wr_idx_c  = i_q;
    wr_data_c = back_w_c ^ temp_c;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (legal_c) begin
            nk_d    = nk_req_c;
            nr_d    = nk_req_c + 4'd6;
            key_d   = key_in;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        i_d     = IW'(nk_q);
        mod_d   = 3'd0;
        rcon_d  = RCON_INIT;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        wr_en_c = 1'b1;
        i_d     = i_q + IW'(1);
        mod_d   = (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
        if (last_c) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_EXPAND);
    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      mod_q   <= '0;
      rcon_q  <= RCON_INIT;
      nk_q    <= '0;
      nr_q    <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mod_q   <= mod_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Store: the cipher key lands in one cycle, expanded words one per cycle after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < int'(DEPTH); j++) w_q[j] <= '0;
    end else if (load_c) begin
      for (int j = 0; j < int'(MAX_NK); j++) begin
        if (j < int'(nk_q)) w_q[j] <= key_q[KW-1-32*j -: 32];
      end
    end else if (wr_en_c) begin
      w_q[wr_idx_c] <= wr_data_c;
    end
  end

  always_comb begin
    r_c    = rd_dec ? RW'(32'(nr_q) - 32'(rd_idx)) : rd_idx;
    base_c = IW'(32'(r_c) * 32'd4);
    if (ready_q && (32'(rd_idx) <= 32'(nr_q))) begin
      rd_key = {w_q[base_c], w_q[base_c + IW'(1)], w_q[base_c + IW'(2)], w_q[base_c + IW'(3)]};
    end else begin
      rd_key = '0;
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign nr    = nr_q;

endmodule

// File: tb/tb_aes_key_schedule_store.sv
// Scoreboard bench for aes_key_schedule_store using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule_store;

  localparam int unsigned MAX_NK = 8;
  localparam int unsigned RW     = 4;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         key_len = 2'b00;
  logic [32*MAX_NK-1:0] key_in = '0;
  logic               busy, ready, err;
  logic [3:0]         nr;
  logic [RW-1:0]      rd_idx = '0;
  logic               rd_dec = 1'b0;
  logic [127:0]       rd_key;

  logic               b_start = 1'b0;
  logic [1:0]         b_key_len = 2'b00;
  logic [127:0]       b_key_in = '0;
  logic               b_busy, b_ready, b_err;
  logic [3:0]         b_nr;
  logic [3:0]         b_rd_idx = '0;
  logic               b_rd_dec = 1'b0;
  logic [127:0]       b_rd_key;

  typedef struct {
    int           kind;
    logic [127:0] exp;
    string        name;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         cur;
  logic [127:0] act;
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           lat = 0;

  aes_key_schedule_store #(.MAX_NK(MAX_NK), .RW(RW)) dut (
    .clk (clk), .rst (rst), .start (start), .key_len (key_len), .key_in (key_in),
    .busy (busy), .ready (ready), .err (err), .nr (nr),
    .rd_idx (rd_idx), .rd_dec (rd_dec), .rd_key (rd_key)
  );

  aes_key_schedule_store #(.MAX_NK(4), .RW(4)) dut4 (
    .clk (clk), .rst (rst), .start (b_start), .key_len (b_key_len), .key_in (b_key_in),
    .busy (b_busy), .ready (b_ready), .err (b_err), .nr (b_nr),
    .rd_idx (b_rd_idx), .rd_dec (b_rd_dec), .rd_key (b_rd_key)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [127:0] get_act(input int kind);
    case (kind)
      0:       return rd_key;
      1:       return 128'(nr);
      2:       return 128'({busy, ready, err});
      3:       return 128'(lat);
      4:       return 128'({b_busy, b_ready, b_err});
      5:       return 128'(b_nr);
      default: return 128'(b_rd_key);
    endcase
  endfunction

  // Monitor: drains every expectation queued since the last falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = get_act(cur.kind);
      n_chk++;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic chk(input int kind, input string name, input logic [127:0] exp);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input int idx, input logic dec, input string name, input logic [127:0] exp);
    rd_idx = RW'(idx);
    rd_dec = dec;
    chk(0, name, exp);
  endtask

  task automatic pulse(input logic [1:0] kl, input logic [255:0] key);
    start   = 1'b1;
    key_len = kl;
    key_in  = key;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] kl, input logic [255:0] key);
    pulse(kl, key);
    start_cyc = cyc - 1;
  endtask

  task automatic wait_ready(input string name, input int exp_lat);
    while (!ready && (cyc - start_cyc) < 200) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - start_cyc;
    chk(3, name, 128'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk(2, "rst_status", 128'(3'b000));
    chk(1, "rst_nr", 128'd0);
    rd(0, 1'b0, "rst_rdkey", 128'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;

    // Reserved key length while idle
    pulse(2'b11, K256);
    chk(2, "rsv_err_pulse", 128'(3'b001));
    chk(2, "rsv_err_clear", 128'(3'b000));
    rd(0, 1'b0, "rsv_rdkey", 128'd0);

    // AES-256 request on a 128-only instance
    b_key_len = 2'b10;
    b_key_in  = K128;
    b_start   = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    chk(4, "nk4_err_pulse", 128'(3'b001));
    chk(4, "nk4_err_clear", 128'(3'b000));
    chk(5, "nk4_nr", 128'd0);

    // AES-128
    do_start(2'b00, {K128, 128'hdeadbeef_cafef00d_12345678_9abcdef0});
    chk(2, "a128_load_busy", 128'(3'b100));
    wait_ready("a128_latency", 42);
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL a128_ready_direct: ready=%b", ready);
    end
    chk(1, "a128_nr", 128'd10);
    rd(10, 1'b0, "a128_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(0, 1'b1, "a128_dec0", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(0, 1'b0, "a128_r0", K128);
    if (rd_key !== K128) begin
      n_fail++;
      $display("FAIL a128_r0_direct: got %h", rd_key);
    end
    rd(1, 1'b0, "a128_r1", 128'ha0fafe1788542cb123a339392a6c7605);
    rd(1, 1'b1, "a128_dec1", 128'hac7766f319fadc2128d12941575c006e);
    rd(11, 1'b0, "a128_oob", 128'd0);

    // Reserved start while done leaves the schedule intact
    pulse(2'b11, K256);
    chk(2, "done_rsv_status", 128'(3'b011));
    chk(1, "done_rsv_nr", 128'd10);
    rd(10, 1'b0, "done_rsv_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192 restart from done
    do_start(2'b01, {K192, 64'hffff_ffff_ffff_ffff});
    wait_ready("a192_latency", 48);
    if (nr !== 4'd12) begin
      n_fail++;
      $display("FAIL a192_nr_direct: nr=%0d", nr);
    end
    chk(1, "a192_nr", 128'd12);
    rd(12, 1'b0, "a192_r12", 128'he98ba06f448c773c8ecc720401002202);
    rd(0, 1'b0, "a192_r0", K192[191:64]);
    rd(1, 1'b0, "a192_r1", 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd(0, 1'b1, "a192_dec0", 128'he98ba06f448c773c8ecc720401002202);

    // AES-128 with a start pulse in the middle of expansion
    do_start(2'b00, {K128, 128'h0});
    repeat (10) @(posedge clk);
    #1;
    start   = 1'b1;
    key_len = 2'b10;
    key_in  = ~K256;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_start_direct: busy=%b err=%b", busy, err);
    end
    chk(2, "mid_start_ignored", 128'(3'b100));
    wait_ready("mid_start_latency", 42);
    chk(1, "mid_start_nr", 128'd10);
    rd(10, 1'b0, "mid_start_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(1, 1'b0, "mid_start_r1", 128'ha0fafe1788542cb123a339392a6c7605);

    // AES-256 restart from done
    do_start(2'b10, K256);
    chk(2, "a256_restart_status", 128'(3'b100));
    wait_ready("a256_latency", 54);
    chk(1, "a256_nr", 128'd14);
    rd(14, 1'b0, "a256_r14", 128'hfe4890d1e6188d0b046df344706c631e);
    if (rd_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      n_fail++;
      $display("FAIL a256_r14_direct: got %h", rd_key);
    end
    rd(14, 1'b1, "a256_dec14", 128'h603deb1015ca71be2b73aef0857d7781);
    rd(1, 1'b0, "a256_r1", 128'h1f352c073b6108d72d9810a30914dff4);
    rd(2, 1'b0, "a256_r2", 128'h9ba354118e6925afa51a8b5f2067fcde);
    rd(15, 1'b0, "a256_oob", 128'd0);
    rd(15, 1'b1, "a256_oob_dec", 128'd0);

    // Reset in the middle of expansion
    do_start(2'b00, {K128, 128'h0});
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    if (busy !== 1'b0 || ready !== 1'b0 || nr !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_direct: busy=%b ready=%b nr=%0d", busy, ready, nr);
    end
    chk(2, "midrst_status", 128'(3'b000));
    chk(1, "midrst_nr", 128'd0);
    rd(0, 1'b0, "midrst_rdkey", 128'd0);
    rst = 1'b1;
    chk(2, "post_rst_idle", 128'(3'b000));

    if (n_chk < 12) begin
      n_fail++;
      $display("FAIL too few checks: %0d", n_chk);
    end
    if (n_fail == 0) $display("PASS");
    else $display("FAIL %0d failures", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
